// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one host packet (up to 63 payload bytes) and then
// streams header, payload and an XOR parity byte to a router input port,
// obeying the router's busy stall. After the parity byte it watches the
// router error flag for a short window and reports per-packet status.
module router_pkt_tx #(
  parameter int unsigned ERR_WAIT = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] dest_addr_i,
  input  logic [5:0] payload_len_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  input  logic       corrupt_parity_i,
  input  logic       busy_i,
  input  logic       router_error_i,
  output logic       pkt_valid_o,
  output logic [7:0] data_out_o,
  output logic       tx_active_o,
  output logic       done_o,
  output logic       pkt_err_o
);

  localparam int CW = (ERR_WAIT < 1) ? 1 : $clog2(ERR_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    PARITY   = 3'd4,
    WAIT_ERR = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      hdr_q, hdr_d;
  logic [5:0]      len_q, len_d;
  logic            corrupt_q, corrupt_d;
  logic [5:0]      idx_q, idx_d;
  logic [7:0]      par_q, par_d;
  logic [7:0]      data_q, data_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            done_q, done_d;
  logic            pkt_err_q, pkt_err_d;
  logic            err_seen_q, err_seen_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            buf_we_s;
  logic [7:0]      buf_q [64];

  assign in_ready_o  = (state_q == LOAD);
  assign tx_active_o = (state_q != IDLE);
  assign pkt_valid_o = pkt_valid_q;
  assign data_out_o  = data_q;
  assign done_o      = done_q;
  assign pkt_err_o   = pkt_err_q;

  // Payload buffer write port; contents intentionally survive reset.
  always_ff @(posedge clock_i) begin
    if (buf_we_s) begin
      buf_q[idx_q] <= in_data_i;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      hdr_q       <= 8'd0;
      len_q       <= 6'd0;
      corrupt_q   <= 1'b0;
      idx_q       <= 6'd0;
      par_q       <= 8'd0;
      data_q      <= 8'd0;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_seen_q  <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      corrupt_q   <= corrupt_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      pkt_err_q   <= pkt_err_d;
      err_seen_q  <= err_seen_d;
      wait_q      <= wait_d;
    end
  end

  // Next-state and output-register logic; busy=0 in a send state means the
  // byte currently on data_out is taken by the router at this edge.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    corrupt_d   = corrupt_q;
    idx_d       = idx_q;
    par_d       = par_q;
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    pkt_err_d   = 1'b0;
    err_seen_d  = err_seen_q;
    wait_d      = wait_q;
    buf_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (dest_addr_i == 2'd3) begin
            done_d    = 1'b1;
            pkt_err_d = 1'b1;
          end else begin
            hdr_d     = {payload_len_i, dest_addr_i};
            len_d     = payload_len_i;
            corrupt_d = corrupt_parity_i;
            idx_d     = 6'd0;
            par_d     = 8'd0;
            if (payload_len_i == 6'd0) begin
              state_d     = HEADER;
              data_d      = {payload_len_i, dest_addr_i};
              pkt_valid_d = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (in_valid_i) begin
          buf_we_s = 1'b1;
          idx_d    = idx_q + 6'd1;
          if (idx_q == (len_q - 6'd1)) begin
            state_d     = HEADER;
            data_d      = hdr_q;
            pkt_valid_d = 1'b1;
            idx_d       = 6'd0;
          end
        end
      end
      HEADER: begin
        if (!busy_i) begin
          par_d = par_q ^ data_q;
          if (len_q == 6'd0) begin
            state_d     = PARITY;
            data_d      = par_q ^ data_q ^ {7'd0, corrupt_q};
            pkt_valid_d = 1'b0;
          end else begin
            state_d = PAYLOAD;
            data_d  = buf_q[6'd0];
            idx_d   = 6'd1;
          end
        end
      end
      PAYLOAD: begin
        if (!busy_i) begin
          par_d = par_q ^ data_q;
          if (idx_q < len_q) begin
            data_d = buf_q[idx_q];
            idx_d  = idx_q + 6'd1;
          end else begin
            state_d     = PARITY;
            data_d      = par_q ^ data_q ^ {7'd0, corrupt_q};
            pkt_valid_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (!busy_i) begin
          state_d    = WAIT_ERR;
          data_d     = 8'd0;
          err_seen_d = 1'b0;
          wait_d     = CW'(ERR_WAIT);
        end
      end
      WAIT_ERR: begin
        err_seen_d = err_seen_q | router_error_i;
        if (wait_q == '0) begin
          done_d    = 1'b1;
          pkt_err_d = err_seen_q | router_error_i;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed plus randomized bench for router_pkt_tx. Expected byte streams and
// status are computed from the packet description (header formula, XOR of all
// sent bytes, error window length), not from the design's state machine.
module tb_router_pkt_tx;

  localparam int ERR_WAIT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       corrupt_parity;
  logic       busy;
  logic       router_error;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       pkt_err;

  int checks = 0;
  int failures = 0;

  router_pkt_tx #(.ERR_WAIT(ERR_WAIT)) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .start_i         (start),
    .dest_addr_i     (dest_addr),
    .payload_len_i   (payload_len),
    .in_valid_i      (in_valid),
    .in_data_i       (in_data),
    .in_ready_o      (in_ready),
    .corrupt_parity_i(corrupt_parity),
    .busy_i          (busy),
    .router_error_i  (router_error),
    .pkt_valid_o     (pkt_valid),
    .data_out_o      (data_out),
    .tx_active_o     (tx_active),
    .done_o          (done),
    .pkt_err_o       (pkt_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pkt_valid"}, {7'd0, pkt_valid}, 8'd0);
    chk({tag, "_data_out"}, data_out, 8'd0);
    chk({tag, "_tx_active"}, {7'd0, tx_active}, 8'd0);
    chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_pkt_err"}, {7'd0, pkt_err}, 8'd0);
  endtask

  // Runs one packet. Entered and left just after a falling clock edge.
  task automatic run_pkt(input logic [1:0] dest, input int len, input bit corrupt,
                         input bit fixed, input int busy_idx, input int busy_n,
                         input int err_delay, input bit spur, input bit chain,
                         input int rst_at);
    logic [7:0] pl [64];
    logic [7:0] expq [$];
    logic [7:0] fixed_bytes [3];
    logic [7:0] p;
    bit exp_err;
    int i;
    int stalls;
    fixed_bytes[0] = 8'h11; fixed_bytes[1] = 8'h22; fixed_bytes[2] = 8'h33;
    for (int j = 0; j < 64; j++) pl[j] = 8'($urandom);
    if (fixed) for (int j = 0; j < 3; j++) pl[j] = fixed_bytes[j];
    // Reference stream: header, payload, then XOR of everything sent.
    p = {6'(len), dest};
    expq.push_back(p);
    for (int j = 0; j < len; j++) begin
      expq.push_back(pl[j]);
      p = p ^ pl[j];
    end
    expq.push_back(p ^ {7'd0, corrupt});
    exp_err = (err_delay >= 1) && (err_delay <= ERR_WAIT + 1);

    start = 1'b1; dest_addr = dest; payload_len = 6'(len); corrupt_parity = corrupt;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dest_addr = 2'($urandom); payload_len = 6'($urandom); corrupt_parity = 1'($urandom);
    if (dest == 2'd3) begin
      chk("rej_done", {7'd0, done}, 8'd1);
      chk("rej_pkt_err", {7'd0, pkt_err}, 8'd1);
      chk("rej_pkt_valid", {7'd0, pkt_valid}, 8'd0);
      chk("rej_in_ready", {7'd0, in_ready}, 8'd0);
      chk("rej_tx_active", {7'd0, tx_active}, 8'd0);
      @(negedge clk);
      chk("rej_done_clear", {7'd0, done}, 8'd0);
      chk("rej_in_ready2", {7'd0, in_ready}, 8'd0);
      chk("rej_pkt_valid2", {7'd0, pkt_valid}, 8'd0);
      return;
    end
    chk("start_done_low", {7'd0, done}, 8'd0);
    chk("start_tx_active", {7'd0, tx_active}, 8'd1);
    chk("start_in_ready", {7'd0, in_ready}, {7'd0, (len != 0)});

    i = 0;
    while (i < len) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = pl[i];
        i++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;

    for (int k = 0; k <= len + 1; k++) begin
      stalls = (k == busy_idx) ? busy_n : (($urandom_range(0, 3) == 0) ? 1 : 0);
      for (int s = 0; s <= stalls; s++) begin
        chk("tx_data", data_out, expq[k]);
        chk("tx_valid", {7'd0, pkt_valid}, {7'd0, (k <= len)});
        chk("tx_in_ready", {7'd0, in_ready}, 8'd0);
        if (k == rst_at) begin
          #2 rst = 1'b1;
          #1 chk_all_zero("async_rst");
          busy = 1'b0; start = 1'b0;
          repeat (2) @(negedge clk);
          rst = 1'b0;
          for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_done", {7'd0, done}, 8'd0);
            chk("post_rst_idle", {7'd0, tx_active}, 8'd0);
          end
          return;
        end
        start = spur && (k == 1) && (s == 0);
        busy = (s < stalls);
        @(posedge clk);
        @(negedge clk);
      end
    end
    start = 1'b0;
    busy = 1'b0;

    for (int c = 1; c <= ERR_WAIT + 1; c++) begin
      chk("wait_data", data_out, 8'd0);
      chk("wait_valid", {7'd0, pkt_valid}, 8'd0);
      chk("wait_done_low", {7'd0, done}, 8'd0);
      chk("wait_active", {7'd0, tx_active}, 8'd1);
      router_error = (c == err_delay);
      @(posedge clk);
      @(negedge clk);
    end
    router_error = 1'b0;
    chk("end_done", {7'd0, done}, 8'd1);
    chk("end_pkt_err", {7'd0, pkt_err}, {7'd0, exp_err});
    chk("end_idle", {7'd0, tx_active}, 8'd0);
    if (!chain) begin
      @(negedge clk);
      chk("done_clear", {7'd0, done}, 8'd0);
      chk("pkt_err_clear", {7'd0, pkt_err}, 8'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dest_addr = 2'd0; payload_len = 6'd0;
    in_valid = 1'b0; in_data = 8'd0; corrupt_parity = 1'b0;
    busy = 1'b0; router_error = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // 1: basic 3-byte packet
    run_pkt(2'd1, 3, 1'b0, 1'b1, -1, 0, 0, 1'b0, 1'b0, -1);
    // 2: empty payload, chained straight into 3
    run_pkt(2'd2, 0, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b1, -1);
    // 3: busy held 3 cycles while 22 is on the bus
    run_pkt(2'd1, 3, 1'b0, 1'b1, 2, 3, 0, 1'b0, 1'b0, -1);
    // 4: corrupted parity and router error 2 cycles after parity
    run_pkt(2'd1, 3, 1'b1, 1'b1, -1, 0, 2, 1'b0, 1'b0, -1);
    // 5: illegal destination, then stray start during a packet
    run_pkt(2'd3, 5, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0, -1);
    run_pkt(2'd1, 3, 1'b0, 1'b1, -1, 0, 0, 1'b1, 1'b0, -1);
    // 6: reset in the middle of a 63-byte packet, then test 1 again
    run_pkt(2'd0, 63, 1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0, 10);
    run_pkt(2'd1, 3, 1'b0, 1'b1, -1, 0, 0, 1'b0, 1'b0, -1);
    // full-length packet with error on the last sampled cycle
    run_pkt(2'd2, 63, 1'b1, 1'b0, 62, 2, ERR_WAIT + 1, 1'b0, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      int len_r;
      case ($urandom_range(0, 5))
        0: len_r = 0;
        1: len_r = 63;
        default: len_r = int'($urandom_range(1, 20));
      endcase
      run_pkt(2'($urandom), len_r, 1'($urandom), 1'b0,
              int'($urandom_range(0, 22)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, ERR_WAIT + 3)), 1'($urandom),
              1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
